osd_rst_seq: RTL and testbench
==============================

OSD_RST_SEQ -- requirements
Module: osd_rst_seq

Interface
REQ-001 Parameter SYS_HOLD, default 16: minimum number of cycles sys_rst_out is held in one system reset; legal range 1..65535.
REQ-002 Parameter CPU_DELAY, default 8: cycles cpu_rst_out stays asserted after sys_rst_out releases, and the minimum CPU-only reset width; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 scm_sys_rst  input  1  system reset request from the subnet control module (level).
REQ-006 scm_cpu_rst  input  1  CPU-only reset request from the subnet control module (level).
REQ-007 sys_rst_out  output  1  registered system reset to the SoC fabric, active-high.
REQ-008 cpu_rst_out  output  1  registered CPU reset to the cores, active-high.
REQ-009 busy  output  1  high whenever the state is not RUN.

Function
REQ-010 The block SHALL implement states SYS_HOLD, SYS_WAIT, CPU_DELAY, CPU_HOLD, RUN with one shared cycle counter sized for max(SYS_HOLD, CPU_DELAY).
REQ-011 All outputs SHALL be registered and SHALL be a pure function of the current state.
REQ-012 SYS_HOLD: sys_rst_out=1, cpu_rst_out=1; the state SHALL last exactly SYS_HOLD cycles, then go to SYS_WAIT if scm_sys_rst=1, else to CPU_DELAY.
REQ-013 SYS_WAIT: sys_rst_out=1, cpu_rst_out=1; the block SHALL go to CPU_DELAY in the cycle after scm_sys_rst is sampled 0.
REQ-014 CPU_DELAY: sys_rst_out=0, cpu_rst_out=1; the state SHALL last exactly CPU_DELAY cycles, then go to CPU_HOLD if scm_cpu_rst=1, else to RUN.
REQ-015 RUN: both outputs 0; scm_sys_rst=1 -> SYS_HOLD; else scm_cpu_rst=1 -> CPU_HOLD; these SHALL be visible on the outputs one cycle after the request is sampled.
REQ-016 CPU_HOLD: sys_rst_out=0, cpu_rst_out=1; the block SHALL go to RUN once at least CPU_DELAY cycles have elapsed in the state and scm_cpu_rst is sampled 0.
REQ-017 scm_sys_rst=1 in CPU_DELAY, CPU_HOLD or RUN SHALL enter SYS_HOLD with the counter cleared, restarting the full sequence.
REQ-018 scm_sys_rst=1 in SYS_HOLD SHALL NOT restart the counter.
REQ-019 When both requests are active in the same cycle, scm_sys_rst SHALL take priority.
REQ-020 scm_cpu_rst SHALL be ignored in SYS_HOLD and SYS_WAIT.
REQ-021 cpu_rst_out SHALL never be 0 while sys_rst_out is 1.
REQ-022 The counter SHALL clear on every state entry and SHALL saturate, never wrap, in SYS_WAIT and CPU_HOLD.

Reset
REQ-023 While rst=1 the block SHALL hold state SYS_HOLD with the counter at 0, sys_rst_out=1, cpu_rst_out=1 and busy=1.
REQ-024 After rst falls, the full power-on sequence SHALL run from SYS_HOLD without any request.
REQ-025 rst asserted mid-sequence SHALL abort the sequence and re-enter SYS_HOLD with the counter at 0 on the next edge.

Configuration
REQ-026 With macro OSD_RST_SEQ_STATUS_EN defined, the block SHALL add output sys_rst_count[7:0]. The counter resets to 0, increments once per SYS_HOLD entry after reset, and saturates at 255.
REQ-027 With OSD_RST_SEQ_STATUS_EN undefined, sys_rst_count and its logic SHALL be absent; all other behaviour is identical.

Verification (SYS_HOLD=16, CPU_DELAY=8)
REQ-028 rst high 3 cycles then low, no requests -> sys_rst_out high 16 cycles after rst falls, cpu_rst_out high 8 cycles more, then busy=0.
REQ-029 In RUN, scm_sys_rst high 40 cycles -> sys_rst_out high 41 cycles starting the next cycle, then cpu_rst_out alone high 8 cycles.
REQ-030 In RUN, scm_cpu_rst 1-cycle pulse -> cpu_rst_out high exactly 8 cycles, sys_rst_out stays 0.
REQ-031 scm_cpu_rst and scm_sys_rst asserted in the same RUN cycle -> SYS_HOLD is entered and sys_rst_out=1 the next cycle.
REQ-032 scm_sys_rst pulse in cycle 4 of CPU_DELAY -> sys_rst_out reasserts for 16 cycles, followed by 8 cycles of cpu_rst_out only.
REQ-033 With OSD_RST_SEQ_STATUS_EN, 300 system reset requests -> sys_rst_count reads 255; rst returns it to 0.

Source files
------------

// File: rtl/osd_rst_seq.sv
// osd_rst_seq -- system / CPU reset sequencer driven by the subnet control module.
// Sequence: SYS_HOLD -> (SYS_WAIT) -> CPU_DELAY -> RUN, plus CPU-only resets via CPU_HOLD.
// Optional status: define OSD_RST_SEQ_STATUS_EN to add sys_rst_count[7:0], a saturating
// count of system reset entries since the last rst.
module osd_rst_seq #(
   parameter int unsigned SYS_HOLD  = 16,
   parameter int unsigned CPU_DELAY = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scm_sys_rst,
   input  logic       scm_cpu_rst,
   output logic       sys_rst_out,
   output logic       cpu_rst_out,
   output logic       busy
`ifdef OSD_RST_SEQ_STATUS_EN
   ,
   output logic [7:0] sys_rst_count
`endif
);

   // One counter serves both timed states, so it is sized for the longer of the two.
   localparam int unsigned CNT_MAX = (SYS_HOLD > CPU_DELAY) ? SYS_HOLD : CPU_DELAY;
   localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] SYS_LAST = CW'(SYS_HOLD - 1);
   localparam logic [CW-1:0] CPU_LAST = CW'(CPU_DELAY - 1);
   localparam logic [CW-1:0] CNT_SAT  = '1;

   typedef enum logic [2:0] {
      ST_SYS_HOLD,
      ST_SYS_WAIT,
      ST_CPU_DELAY,
      ST_CPU_HOLD,
      ST_RUN
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;
   logic          sys_req_q;
   logic          sys_rst_q, cpu_rst_q, busy_q;

   // Counter never wraps: it sticks at all-ones in the open-ended states.
   assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

   // Next-state and counter logic; every state change clears the counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_inc;
      case (state_q)
         ST_SYS_HOLD: begin
            // Requests here neither extend nor restart the hold.
            if (cnt_q == SYS_LAST) begin
               state_d = scm_sys_rst ? ST_SYS_WAIT : ST_CPU_DELAY;
               cnt_d   = '0;
            end
         end
         ST_SYS_WAIT: begin
            // Leave one cycle after the request is seen low (registered copy).
            if (!sys_req_q) begin
               state_d = ST_CPU_DELAY;
               cnt_d   = '0;
            end
         end
         ST_CPU_DELAY: begin
            if (scm_sys_rst) begin
               state_d = ST_SYS_HOLD;
               cnt_d   = '0;
            end else if (cnt_q == CPU_LAST) begin
               state_d = scm_cpu_rst ? ST_CPU_HOLD : ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_CPU_HOLD: begin
            if (scm_sys_rst) begin
               state_d = ST_SYS_HOLD;
               cnt_d   = '0;
            end else if ((cnt_q >= CPU_LAST) && !scm_cpu_rst) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            cnt_d = '0;
            if (scm_sys_rst) begin
               state_d = ST_SYS_HOLD;
            end else if (scm_cpu_rst) begin
               state_d = ST_CPU_HOLD;
            end
         end
         default: begin
            state_d = ST_SYS_HOLD;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter and outputs; outputs are decoded from the next state so they track the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_SYS_HOLD;
         cnt_q     <= '0;
         sys_req_q <= 1'b0;
         sys_rst_q <= 1'b1;
         cpu_rst_q <= 1'b1;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sys_req_q <= scm_sys_rst;
         sys_rst_q <= (state_d == ST_SYS_HOLD) || (state_d == ST_SYS_WAIT);
         cpu_rst_q <= (state_d != ST_RUN);
         busy_q    <= (state_d != ST_RUN);
      end
   end

   assign sys_rst_out = sys_rst_q;
   assign cpu_rst_out = cpu_rst_q;
   assign busy        = busy_q;

`ifdef OSD_RST_SEQ_STATUS_EN
   logic [7:0] sys_cnt_q;

   // Count entries into SYS_HOLD from another state; the reset-held SYS_HOLD is not an entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         sys_cnt_q <= '0;
      end else if ((state_d == ST_SYS_HOLD) && (state_q != ST_SYS_HOLD) && (sys_cnt_q != 8'hFF)) begin
         sys_cnt_q <= sys_cnt_q + 8'd1;
      end
   end

   assign sys_rst_count = sys_cnt_q;
`endif

endmodule

// File: tb/tb_osd_rst_seq.sv
// Directed testbench for osd_rst_seq (SYS_HOLD=16, CPU_DELAY=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_osd_rst_seq;

   logic clk;
   logic rst;
   logic scm_sys_rst;
   logic scm_cpu_rst;
   logic sys_rst_out;
   logic cpu_rst_out;
   logic busy;
`ifdef OSD_RST_SEQ_STATUS_EN
   logic [7:0] sys_rst_count;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int inv_bad  = 0;
   int busy_bad = 0;

   osd_rst_seq #(
      .SYS_HOLD  (16),
      .CPU_DELAY (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .scm_sys_rst (scm_sys_rst),
      .scm_cpu_rst (scm_cpu_rst),
      .sys_rst_out (sys_rst_out),
      .cpu_rst_out (cpu_rst_out),
      .busy        (busy)
`ifdef OSD_RST_SEQ_STATUS_EN
      ,
      .sys_rst_count (sys_rst_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("check %-20s got %0d expected %0d ok", tag, got, exp);
      end else begin
         $display("FAIL %-20s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Walk the sequence until busy drops, releasing each request after the given number
   // of sampling edges. Lengths are in cycles, counted at falling edges.
   task automatic measure(input bit sample_now, input int sys_cyc, input int cpu_cyc,
                          output int sys_len, output int cpu_len,
                          output bit first_sys, output bit timed_out);
      int k;
      sys_len   = 0;
      cpu_len   = 0;
      first_sys = 1'b0;
      timed_out = 1'b1;
      k = 0;
      if (!sample_now) begin
         @(negedge clk);
         k = 1;
         if (k >= sys_cyc) scm_sys_rst = 1'b0;
         if (k >= cpu_cyc) scm_cpu_rst = 1'b0;
      end
      for (int i = 0; i < 200; i++) begin
         if (i == 0) first_sys = sys_rst_out;
         if (sys_rst_out && !cpu_rst_out) inv_bad++;
         if (busy !== cpu_rst_out) busy_bad++;
         if (sys_rst_out) begin
            sys_len++;
         end else if (cpu_rst_out) begin
            cpu_len++;
         end else begin
            timed_out = 1'b0;
            break;
         end
         @(negedge clk);
         k++;
         if (k >= sys_cyc) scm_sys_rst = 1'b0;
         if (k >= cpu_cyc) scm_cpu_rst = 1'b0;
      end
   endtask

   task automatic run_seq(input string tag, input bit sample_now, input int sys_cyc,
                          input int cpu_cyc, input int exp_sys, input int exp_cpu);
      int sl, cl;
      bit fs, to;
      measure(sample_now, sys_cyc, cpu_cyc, sl, cl, fs, to);
      check({tag, "_tmo"},   32'(to), 32'd0);
      check({tag, "_first"}, 32'(fs), 32'(exp_sys != 0));
      check({tag, "_sys"},   32'(sl), 32'(exp_sys));
      check({tag, "_cpu"},   32'(cl), 32'(exp_cpu));
   endtask

   initial begin
      int w;
      rst         = 1'b1;
      scm_sys_rst = 1'b0;
      scm_cpu_rst = 1'b0;

      // Reset held for three edges
      repeat (3) @(negedge clk);
      check("rst_sys", 32'(sys_rst_out), 32'd1);
      check("rst_cpu", 32'(cpu_rst_out), 32'd1);
      check("rst_busy", 32'(busy), 32'd1);
`ifdef OSD_RST_SEQ_STATUS_EN
      check("rst_count", 32'(sys_rst_count), 32'd0);
`endif

      // Power-on sequence without requests: 16 sys cycles then 8 cpu-only
      rst = 1'b0;
      run_seq("poweron", 1'b1, 0, 0, 16, 8);
      repeat (3) @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_sys", 32'(sys_rst_out), 32'd0);
      check("idle_cpu", 32'(cpu_rst_out), 32'd0);

      // Long system request: 40 cycles -> 41 sys cycles, 8 cpu-only
      scm_sys_rst = 1'b1;
      run_seq("sys40", 1'b0, 40, 0, 41, 8);

      // Single-cycle CPU pulse -> 8 cpu cycles, no sys
      @(negedge clk);
      scm_cpu_rst = 1'b1;
      run_seq("cpu1", 1'b0, 0, 1, 0, 8);

      // CPU request held 20 cycles -> 20 cpu cycles
      @(negedge clk);
      scm_cpu_rst = 1'b1;
      run_seq("cpu20", 1'b0, 0, 20, 0, 20);

      // Both requests in the same cycle: system reset wins
      @(negedge clk);
      scm_sys_rst = 1'b1;
      scm_cpu_rst = 1'b1;
      run_seq("both", 1'b0, 1, 1, 16, 8);

      // CPU request held through the whole system reset: ignored in SYS_HOLD,
      // then CPU_DELAY (8) followed by CPU_HOLD (8)
      @(negedge clk);
      scm_sys_rst = 1'b1;
      scm_cpu_rst = 1'b1;
      run_seq("sys_cpu30", 1'b0, 1, 30, 16, 16);

      // Second system pulse inside SYS_HOLD does not restart it: 11 cycles remain
      @(negedge clk);
      scm_sys_rst = 1'b1;
      @(negedge clk);
      scm_sys_rst = 1'b0;
      repeat (4) @(negedge clk);
      scm_sys_rst = 1'b1;
      run_seq("sys_rehold", 1'b0, 1, 0, 11, 8);

      // System pulse in cycle 4 of CPU_DELAY restarts the full sequence
      @(negedge clk);
      scm_sys_rst = 1'b1;
      @(negedge clk);
      scm_sys_rst = 1'b0;
      w = 0;
      while (sys_rst_out && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("cd_reach", 32'(w < 100), 32'd1);
      repeat (3) @(negedge clk);
      check("cd4_cpu", 32'(cpu_rst_out), 32'd1);
      check("cd4_sys", 32'(sys_rst_out), 32'd0);
      scm_sys_rst = 1'b1;
      run_seq("cd4_sys_req", 1'b0, 1, 0, 16, 8);

      // rst mid-sequence (during CPU_DELAY) aborts and restarts from SYS_HOLD
      @(negedge clk);
      scm_sys_rst = 1'b1;
      @(negedge clk);
      scm_sys_rst = 1'b0;
      repeat (18) @(negedge clk);
      check("mid_pre_sys", 32'(sys_rst_out), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_sys", 32'(sys_rst_out), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      run_seq("mid_rst", 1'b1, 0, 0, 16, 8);

`ifdef OSD_RST_SEQ_STATUS_EN
      // Status counter: clear, count a few, saturate at 255, clear again
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("cnt_clear", 32'(sys_rst_count), 32'd0);
      w = 0;
      while (busy && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("cnt_poweron_done", 32'(w < 100), 32'd1);
      check("cnt_poweron", 32'(sys_rst_count), 32'd0);
      begin
         int tmo;
         tmo = 0;
         for (int i = 0; i < 300; i++) begin
            scm_sys_rst = 1'b1;
            @(negedge clk);
            scm_sys_rst = 1'b0;
            w = 0;
            while (busy && w < 60) begin
               @(negedge clk);
               w++;
            end
            if (w >= 60) tmo++;
            if (i == 2) check("cnt_3", 32'(sys_rst_count), 32'd3);
         end
         check("cnt_loop_tmo", 32'(tmo), 32'd0);
      end
      check("cnt_sat", 32'(sys_rst_count), 32'd255);
      rst = 1'b1;
      @(negedge clk);
      check("cnt_rst", 32'(sys_rst_count), 32'd0);
      rst = 1'b0;
`endif

      // Invariants gathered across every measured sequence
      check("cpu_under_sys", 32'(inv_bad), 32'd0);
      check("busy_track", 32'(busy_bad), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
